// File: rtl/pattern_detect_ctrl_if.sv
// Handshake and data bundle for pattern_detect_ctrl: run control, serial data,
// pattern load and the display/status outputs.
interface pattern_detect_ctrl_if;
  logic       d_in;
  logic       start;
  logic       stop;
  logic       mode;
  logic       pat_wr;
  logic [3:0] pat_in;
  logic       clr_cnt;
  logic       led_out;
  logic [3:0] shift_q;
  logic [7:0] hit_cnt;
  logic       busy;
  logic       sample_tick;

  modport master (
    output d_in, start, stop, mode, pat_wr, pat_in, clr_cnt,
    input  led_out, shift_q, hit_cnt, busy, sample_tick
  );

  modport slave (
    input  d_in, start, stop, mode, pat_wr, pat_in, clr_cnt,
    output led_out, shift_q, hit_cnt, busy, sample_tick
  );
endinterface

// File: rtl/pattern_detect_ctrl.sv
// Serial 4-bit pattern detector: samples d_in on a divided tick, flags matches
// on led_out for a hold period and keeps a saturating two-digit BCD hit count.
module pattern_detect_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int HOLD_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pattern_detect_ctrl_if.slave  bus
);

  localparam int            CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]    HOLD_LOAD = 4'(HOLD_TICKS);

  typedef enum logic [1:0] {IDLE, FILL, RUN, HIT} state_t;

  state_t        state_q, state_nx;
  logic [CW-1:0] tick_q, tick_nx;
  logic [3:0]    shift_r, shift_nx;
  logic [2:0]    bit_q, bit_nx;
  logic [3:0]    hold_q, hold_nx;
  logic          led_q, led_nx;
  logic [7:0]    hit_q, hit_nx;
  logic [3:0]    pat_q, pat_nx;

  logic          tick;
  logic [3:0]    shifted;
  logic [2:0]    bit_inc;
  logic          match;
  logic [7:0]    hit_inc;

  assign tick    = (state_q != IDLE) && (tick_q == TICK_LAST);
  assign shifted = {shift_r[2:0], bus.d_in};
  assign bit_inc = (bit_q == 3'd4) ? 3'd4 : bit_q + 3'd1;
  assign match   = tick && (bit_inc == 3'd4) && (shifted == pat_q);

  // BCD increment that sticks at 99 rather than wrapping
  assign hit_inc = (hit_q == 8'h99)       ? 8'h99 :
                   (hit_q[3:0] == 4'd9)   ? {hit_q[7:4] + 4'd1, 4'd0} :
                                            {hit_q[7:4], hit_q[3:0] + 4'd1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      shift_r <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      led_q   <= 1'b0;
      hit_q   <= '0;
      pat_q   <= 4'b0110;
    end else begin
      state_q <= state_nx;
      tick_q  <= tick_nx;
      shift_r <= shift_nx;
      bit_q   <= bit_nx;
      hold_q  <= hold_nx;
      led_q   <= led_nx;
      hit_q   <= hit_nx;
      pat_q   <= pat_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    tick_nx  = tick_q;
    shift_nx = shift_r;
    bit_nx   = bit_q;
    hold_nx  = hold_q;
    led_nx   = led_q;
    hit_nx   = hit_q;
    pat_nx   = pat_q;

    case (state_q)
      IDLE: begin
        tick_nx = '0;
        if (bus.pat_wr) pat_nx = bus.pat_in;
        if (bus.start && !bus.stop) begin
          state_nx = FILL;
          shift_nx = '0;
          bit_nx   = '0;
        end
      end
      default: begin
        // stop abandons the run but leaves the displayed bits and count alone
        if (bus.stop) begin
          state_nx = IDLE;
          tick_nx  = '0;
          led_nx   = 1'b0;
        end else begin
          tick_nx = tick ? '0 : tick_q + CW'(1);
          if (tick) begin
            shift_nx = shifted;
            bit_nx   = bit_inc;
            if (match) begin
              state_nx = HIT;
              led_nx   = 1'b1;
              hold_nx  = HOLD_LOAD;
              hit_nx   = hit_inc;
              if (bus.mode) bit_nx = '0;
            end else if (state_q == FILL) begin
              if (bit_inc == 3'd4) state_nx = RUN;
            end else if (state_q == HIT) begin
              hold_nx = hold_q - 4'd1;
              if (hold_q == 4'd1) begin
                led_nx   = 1'b0;
                state_nx = RUN;
              end
            end
          end
        end
      end
    endcase

    if (bus.clr_cnt) hit_nx = '0;
  end

  assign bus.led_out     = led_q;
  assign bus.shift_q     = shift_r;
  assign bus.hit_cnt     = hit_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.sample_tick = tick;

endmodule
